// File: rtl/ov5640_pwr_monitor.sv
// OV5640 power-sequence monitor.
// Samples the PWDN/RESETB pins driven by the power controller, follows the
// sensor through power-down, wake and internal-init phases, reports readiness
// once the init delay has elapsed, and latches the first sequencing violation.
module ov5640_pwr_monitor #(
  parameter int unsigned T_PWDN_MIN = 300000,
  parameter int unsigned T_RST_MIN  = 50000,
  parameter int unsigned T_INIT     = 1000000,
  parameter int unsigned CNT_W      = 20
) (
  input  logic       sclk,
  input  logic       s_rst_n,
  input  logic       ov5640_pwdn,
  input  logic       ov5640_resetb,
  input  logic       err_clr,
  output logic       sensor_ready,
  output logic       seq_err,
  output logic [2:0] err_code,
  output logic [1:0] state
);

  // Sequence states
  localparam logic [1:0] S_PWDN  = 2'd0;
  localparam logic [1:0] S_WAKE  = 2'd1;
  localparam logic [1:0] S_INIT  = 2'd2;
  localparam logic [1:0] S_READY = 2'd3;

  // Error codes
  localparam logic [2:0] ERR_NONE       = 3'd0;
  localparam logic [2:0] ERR_PWDN_SHORT = 3'd1;
  localparam logic [2:0] ERR_ORDER      = 3'd2;
  localparam logic [2:0] ERR_RST_EARLY  = 3'd3;
  localparam logic [2:0] ERR_GLITCH     = 3'd4;

  // Timing thresholds in counter width
  localparam logic [CNT_W-1:0] PWDN_MIN  = CNT_W'(T_PWDN_MIN);
  localparam logic [CNT_W-1:0] RST_MIN   = CNT_W'(T_RST_MIN);
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(T_INIT - 1);

  logic             pwdn_q, resetb_q;   // previous pin samples
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             seq_err_q;
  logic [2:0]       err_code_q;

  logic             pwdn_rise, pwdn_fall, resetb_rise, resetb_fall, pin_event;
  logic             err_set;
  logic [2:0]       err_new;

  // Edge events act at the same clock edge that first sees the new pin value.
  always_comb begin
    pwdn_rise   = ov5640_pwdn & ~pwdn_q;
    pwdn_fall   = ~ov5640_pwdn & pwdn_q;
    resetb_rise = ov5640_resetb & ~resetb_q;
    resetb_fall = ~ov5640_resetb & resetb_q;
    pin_event   = pwdn_rise | pwdn_fall | resetb_rise | resetb_fall;
  end

  // Next-state decode and violation detection; PWDN rise always takes priority.
  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    err_new = ERR_NONE;
    case (state_q)
      S_PWDN: begin
        if (resetb_rise) begin
          err_set = 1'b1;
          err_new = ERR_ORDER;
          state_d = S_INIT;
        end else if (pwdn_fall) begin
          if (!ov5640_resetb) begin
            state_d = S_WAKE;
            if (cnt_q < PWDN_MIN) begin
              err_set = 1'b1;
              err_new = ERR_PWDN_SHORT;
            end
          end else begin
            // Reset was already released while powered down: out of order.
            err_set = 1'b1;
            err_new = ERR_ORDER;
            state_d = S_INIT;
          end
        end
      end
      S_WAKE: begin
        if (pwdn_rise) begin
          state_d = S_PWDN;
        end else if (resetb_rise) begin
          state_d = S_INIT;
          if (cnt_q < RST_MIN) begin
            err_set = 1'b1;
            err_new = ERR_RST_EARLY;
          end
        end
      end
      S_INIT: begin
        if (pwdn_rise) begin
          err_set = 1'b1;
          err_new = ERR_GLITCH;
          state_d = S_PWDN;
        end else if (resetb_fall) begin
          err_set = 1'b1;
          err_new = ERR_GLITCH;
          state_d = ov5640_pwdn ? S_PWDN : S_WAKE;
        end else if (!pin_event && (cnt_q == INIT_LAST)) begin
          state_d = S_READY;
        end
      end
      S_READY: begin
        if (pwdn_rise) begin
          state_d = S_PWDN;
        end else if (resetb_fall) begin
          // Legal re-reset of a running sensor.
          state_d = ov5640_pwdn ? S_PWDN : S_WAKE;
        end
      end
      default: state_d = S_PWDN;
    endcase
  end

  // Counter restarts on each state entry, otherwise counts and saturates.
  always_comb begin
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (&cnt_q) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Pin sampling, state and counter registers.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      pwdn_q   <= 1'b1;
      resetb_q <= 1'b0;
      state_q  <= S_PWDN;
      cnt_q    <= '0;
    end else begin
      pwdn_q   <= ov5640_pwdn;
      resetb_q <= ov5640_resetb;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
    end
  end

  // Sticky first-error latch; a new violation beats a simultaneous clear.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      seq_err_q  <= 1'b0;
      err_code_q <= ERR_NONE;
    end else if (err_set && (!seq_err_q || err_clr)) begin
      seq_err_q  <= 1'b1;
      err_code_q <= err_new;
    end else if (err_clr) begin
      seq_err_q  <= 1'b0;
      err_code_q <= ERR_NONE;
    end
  end

  // Outputs come straight from registers so async reset clears them at once.
  always_comb begin
    state        = state_q;
    sensor_ready = (state_q == S_READY);
    seq_err      = seq_err_q;
    err_code     = err_code_q;
  end

endmodule

// File: tb/tb_ov5640_pwr_monitor.sv
// Directed bench for ov5640_pwr_monitor with short timing parameters.
module tb_ov5640_pwr_monitor;

  logic       sclk = 1'b0;
  logic       s_rst_n;
  logic       ov5640_pwdn;
  logic       ov5640_resetb;
  logic       err_clr;
  logic       sensor_ready;
  logic       seq_err;
  logic [2:0] err_code;
  logic [1:0] state;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;
  logic        watch_ready = 1'b0;
  logic        ready_seen  = 1'b0;

  ov5640_pwr_monitor #(
    .T_PWDN_MIN(10),
    .T_RST_MIN (5),
    .T_INIT    (20),
    .CNT_W     (8)
  ) dut (
    .sclk         (sclk),
    .s_rst_n      (s_rst_n),
    .ov5640_pwdn  (ov5640_pwdn),
    .ov5640_resetb(ov5640_resetb),
    .err_clr      (err_clr),
    .sensor_ready (sensor_ready),
    .seq_err      (seq_err),
    .err_code     (err_code),
    .state        (state)
  );

  always #5 sclk = ~sclk;

  // Records any readiness while a test expects the sensor never to become ready.
  always @(posedge sclk) begin
    if (watch_ready && sensor_ready) ready_seen <= 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance n active edges; inputs driven afterwards are stable well before the next edge.
  task automatic edges(input int n);
    repeat (n) begin
      @(posedge sclk);
      #1;
    end
  endtask

  task automatic apply_reset;
    s_rst_n       = 1'b0;
    ov5640_pwdn   = 1'b1;
    ov5640_resetb = 1'b0;
    err_clr       = 1'b0;
    @(negedge sclk);
    s_rst_n = 1'b1;
  endtask

  initial begin
    // Reset values
    apply_reset();
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_ready", 32'(sensor_ready), 32'd0);
    check_eq("rst_seq_err", 32'(seq_err), 32'd0);
    check_eq("rst_err_code", 32'(err_code), 32'd0);

    // Nominal sequence
    edges(12);
    check_eq("nom_pwdn_state", 32'(state), 32'd0);
    ov5640_pwdn = 1'b0;
    edges(1);
    check_eq("nom_wake_state", 32'(state), 32'd1);
    edges(5);
    ov5640_resetb = 1'b1;
    edges(1);
    check_eq("nom_init_state", 32'(state), 32'd2);
    check_eq("nom_rst_min_ok", 32'(seq_err), 32'd0);
    edges(19);
    check_eq("nom_init_19", 32'(state), 32'd2);
    check_eq("nom_ready_19", 32'(sensor_ready), 32'd0);
    edges(1);
    check_eq("nom_ready_20", 32'(sensor_ready), 32'd1);
    check_eq("nom_ready_state", 32'(state), 32'd3);
    check_eq("nom_seq_err", 32'(seq_err), 32'd0);

    // Short power-down
    apply_reset();
    edges(9);
    ov5640_pwdn = 1'b0;
    edges(1);
    check_eq("short_code", 32'(err_code), 32'd1);
    check_eq("short_seq_err", 32'(seq_err), 32'd1);
    check_eq("short_state", 32'(state), 32'd1);
    edges(5);
    ov5640_resetb = 1'b1;
    edges(21);
    check_eq("short_ready", 32'(state), 32'd3);
    check_eq("short_code_held", 32'(err_code), 32'd1);

    // Order violation, then a later early-reset violation must not overwrite it
    apply_reset();
    edges(3);
    ov5640_resetb = 1'b1;
    edges(1);
    check_eq("order_code", 32'(err_code), 32'd2);
    check_eq("order_state", 32'(state), 32'd2);
    ov5640_pwdn = 1'b0;
    edges(1);
    check_eq("order_pwdn_fall_init", 32'(state), 32'd2);
    ov5640_resetb = 1'b0;
    edges(1);
    check_eq("order_glitch_wake", 32'(state), 32'd1);
    edges(2);
    ov5640_resetb = 1'b1;
    edges(1);
    check_eq("order_early_state", 32'(state), 32'd2);
    check_eq("order_code_held", 32'(err_code), 32'd2);
    check_eq("order_seq_err", 32'(seq_err), 32'd1);

    // Boundary PWDN hold, early reset release, clear, then glitch in init
    apply_reset();
    watch_ready = 1'b1;
    ready_seen  = 1'b0;
    edges(10);
    ov5640_pwdn = 1'b0;
    edges(1);
    check_eq("bnd_pwdn_min_ok", 32'(seq_err), 32'd0);
    check_eq("bnd_wake_state", 32'(state), 32'd1);
    edges(2);
    ov5640_resetb = 1'b1;
    edges(1);
    check_eq("early_code", 32'(err_code), 32'd3);
    err_clr = 1'b1;
    edges(1);
    err_clr = 1'b0;
    check_eq("clr_code", 32'(err_code), 32'd0);
    check_eq("clr_seq_err", 32'(seq_err), 32'd0);
    edges(9);
    ov5640_pwdn = 1'b1;
    edges(1);
    check_eq("glitch_code", 32'(err_code), 32'd4);
    check_eq("glitch_state", 32'(state), 32'd0);
    check_eq("glitch_ready", 32'(sensor_ready), 32'd0);
    edges(1);
    check_eq("glitch_never_ready", 32'(ready_seen), 32'd0);
    watch_ready = 1'b0;

    // Pins already low at the first edge after reset
    apply_reset();
    ov5640_pwdn = 1'b0;
    edges(1);
    check_eq("early_pin_code", 32'(err_code), 32'd1);
    check_eq("early_pin_state", 32'(state), 32'd1);

    // Legal re-reset, set-wins clear, async reset mid-init
    apply_reset();
    edges(10);
    ov5640_pwdn = 1'b0;
    edges(6);
    ov5640_resetb = 1'b1;
    edges(21);
    check_eq("rer_ready", 32'(sensor_ready), 32'd1);
    ov5640_resetb = 1'b0;
    edges(1);
    check_eq("rer_ready_drop", 32'(sensor_ready), 32'd0);
    check_eq("rer_state", 32'(state), 32'd1);
    check_eq("rer_no_err", 32'(seq_err), 32'd0);
    edges(1);
    ov5640_resetb = 1'b1;
    err_clr       = 1'b1;
    edges(1);
    err_clr = 1'b0;
    check_eq("setwins_code", 32'(err_code), 32'd3);
    check_eq("setwins_seq_err", 32'(seq_err), 32'd1);
    check_eq("setwins_state", 32'(state), 32'd2);
    edges(4);
    @(negedge sclk);
    #2;
    s_rst_n = 1'b0;
    #1;
    check_eq("arst_state", 32'(state), 32'd0);
    check_eq("arst_ready", 32'(sensor_ready), 32'd0);
    check_eq("arst_seq_err", 32'(seq_err), 32'd0);
    check_eq("arst_code", 32'(err_code), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
